// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : Multi-channel PWM with a shared prescaler and period counter,
//            edge/center alignment and shadowed, glitch-free duty updates.
// Revision : 1.0
// ============================================================================
module pwm_multi #(
    parameter int  CHANNELS = 4,
    parameter int  DATA_W   = 8,
    parameter int  DIV_W    = 10,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DIV_W-1:0]    div,
    input  logic [DATA_W-1:0]   period,
    input  logic                mode,
    input  logic [CHANNELS-1:0] polarity,
    input  logic                duty_wr,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [DATA_W-1:0]   duty_data,
    output logic [CHANNELS-1:0] pwm,
    output logic                cycle_start
);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_W-1:0]    r_pre;
    logic [DATA_W-1:0]   r_cnt;
    dir_t                r_dir;
    logic [DATA_W-1:0]   r_pending [CHANNELS];
    logic [DATA_W-1:0]   r_active  [CHANNELS];

    logic                w_tick;
    logic                w_boundary;
    logic                w_turn;
    logic [DATA_W-1:0]   w_next;
    logic [CHANNELS-1:0] w_hit;

    assign w_tick = en && (r_pre >= div);

    // The >= tests let a live reduction of period below cnt recover in one tick.
    always_comb begin
        w_next = r_cnt + 1'b1;
        w_turn = 1'b0;
        if (!mode) begin
            if (r_cnt >= period) begin
                w_next = '0;
            end
        end else if (r_dir == DIR_DOWN) begin
            w_next = r_cnt - 1'b1;
        end else if (r_cnt >= period) begin
            w_next = (period == '0) ? '0 : period - 1'b1;
            w_turn = 1'b1;
        end
    end

    assign w_boundary = w_tick && (w_next == '0);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
            assign w_hit[gi] = duty_wr && (duty_sel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_cnt       <= '0;
            r_dir       <= DIR_UP;
            pwm         <= '0;
            cycle_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= '0;
                r_active[i]  <= '0;
            end
        end else begin
            cycle_start <= w_boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_hit[i]) begin
                    r_pending[i] <= duty_data;
                end
            end
            if (!en) begin
                r_pre <= '0;
                r_cnt <= '0;
                r_dir <= DIR_UP;
                pwm   <= polarity;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_active[i] <= r_pending[i];
                end
            end else begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    pwm[i] <= (r_cnt < r_active[i]) ^ polarity[i];
                end
                if (w_tick) begin
                    r_cnt <= w_next;
                    // A write landing on the boundary goes straight to active.
                    if (w_boundary) begin
                        r_dir <= DIR_UP;
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_active[i] <= w_hit[i] ? duty_data : r_pending[i];
                        end
                    end else if (w_turn) begin
                        r_dir <= DIR_DOWN;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Directed and randomized checks of pwm_multi against a model that
//            tracks position within the period rather than counter/direction.
// Revision : 1.0
// ============================================================================
module tb_pwm_multi;
    // Six channels so a 3-bit duty_sel can address beyond the last channel.
    localparam int CH  = 6;
    localparam int DW  = 8;
    localparam int DVW = 10;
    localparam int SW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DVW-1:0] div = '0;
    logic [DW-1:0] period = '0;
    logic          mode = 1'b0;
    logic [CH-1:0] polarity = '0;
    logic          duty_wr = 1'b0;
    logic [SW-1:0] duty_sel = '0;
    logic [DW-1:0] duty_data = '0;
    logic [CH-1:0] pwm;
    logic          cycle_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CHANNELS(CH), .DATA_W(DW), .DIV_W(DVW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .period(period),
        .mode(mode), .polarity(polarity), .duty_wr(duty_wr),
        .duty_sel(duty_sel), .duty_data(duty_data), .pwm(pwm),
        .cycle_start(cycle_start)
    );

    // ---------------- reference model: position k within the period --------
    int m_pre, m_k, m_c, m_plen;
    bit m_tick;
    int m_pend [CH];
    int m_act  [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_cs;

    function automatic int cnt_of(input int k);
        if (!mode || k <= int'(period)) return k;
        return 2 * int'(period) - k;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0; m_k = 0; exp_pwm = '0; exp_cs = 1'b0;
            for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
        end else begin
            m_c = cnt_of(m_k);
            exp_cs = 1'b0;
            if (!en) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
                exp_pwm = polarity; m_pre = 0; m_k = 0;
            end else begin
                for (int i = 0; i < CH; i++) exp_pwm[i] = (m_c < m_act[i]) ^ polarity[i];
                m_tick = (m_pre >= int'(div));
                m_pre  = m_tick ? 0 : m_pre + 1;
                if (m_tick) begin
                    m_plen = mode ? ((period == 0) ? 1 : 2 * int'(period)) : int'(period) + 1;
                    m_k = (m_k + 1 >= m_plen) ? 0 : m_k + 1;
                    if (m_k == 0) begin
                        exp_cs = 1'b1;
                        for (int i = 0; i < CH; i++)
                            m_act[i] = (duty_wr && int'(duty_sel) == i) ? int'(duty_data) : m_pend[i];
                    end
                end
            end
            if (duty_wr && int'(duty_sel) < CH) m_pend[int'(duty_sel)] = int'(duty_data);
        end
    end

    // ---------------- stimulus helpers (drive only, called at a negedge) ----
    task automatic configure(input int d, input int p, input bit m, input logic [CH-1:0] pol);
        en = 1'b0; div = DVW'(d); period = DW'(p); mode = m; polarity = pol;
    endtask

    task automatic write_duty(input int sel, input int data);
        duty_wr = 1'b1; duty_sel = SW'(sel); duty_data = DW'(data);
        @(negedge clk);
        duty_wr = 1'b0;
    endtask

    task automatic enable();
        @(negedge clk);
        en = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (pwm !== '0 || cycle_start !== 1'b0) begin
            errors++; $display("FAIL reset_state: pwm=%b cs=%b required pwm=0 cs=0", pwm, cycle_start);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL reset_idle: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
        end
    endtask

    task automatic test_edge_basic();
        int hi = 0, cs = 0;
        @(negedge clk); configure(0, 9, 1'b0, '0); write_duty(0, 3); enable();
        repeat (40) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL edge_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            hi += int'(pwm[0]); cs += int'(cycle_start);
        end
        checks++;
        if (hi != 12 || cs != 4) begin
            errors++; $display("FAIL edge_shape: highs=%0d starts=%0d required 12 and 4", hi, cs);
        end
    endtask

    task automatic test_prescale();
        int h0 = 0, h1 = 0, h2 = 0, cs = 0;
        @(negedge clk); configure(1, 9, 1'b0, '0); write_duty(1, 0); write_duty(2, 12); enable();
        repeat (80) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL prescale_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            h0 += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]); cs += int'(cycle_start);
        end
        checks++;
        if (h0 != 24 || h1 != 0 || h2 != 80 || cs != 4) begin
            errors++; $display("FAIL prescale_shape: h0=%0d h1=%0d h2=%0d starts=%0d required 24 0 80 4", h0, h1, h2, cs);
        end
    endtask

    task automatic test_shadow();
        int hi = 0, h1 = 0, h2 = 0;
        bit found = 1'b0;
        @(negedge clk); configure(0, 9, 1'b0, '0); enable();
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL shadow_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            found = (m_k == 5);
        end
        write_duty(0, 7); write_duty(6, 200); write_duty(7, 1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL shadow_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            hi += int'(pwm[0]); found = cycle_start;
        end
        checks++;
        if (!found || hi != 0) begin
            errors++; $display("FAIL shadow_hold: start_seen=%0d highs=%0d required 1 and 0", found, hi);
        end
        hi = 0;
        repeat (10) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL shadow_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            hi += int'(pwm[0]); h1 += int'(pwm[1]); h2 += int'(pwm[2]);
        end
        checks++;
        if (hi != 7 || h1 != 0 || h2 != 10) begin
            errors++; $display("FAIL shadow_new: h0=%0d h1=%0d h2=%0d required 7 0 10", hi, h1, h2);
        end
    endtask

    task automatic test_center();
        int hi = 0, cs = 0;
        @(negedge clk); configure(0, 4, 1'b1, '0); write_duty(0, 2); enable();
        repeat (48) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL center_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            hi += int'(pwm[0]); cs += int'(cycle_start);
        end
        checks++;
        if (hi != 18 || cs != 6) begin
            errors++; $display("FAIL center_shape: highs=%0d starts=%0d required 18 and 6", hi, cs);
        end
    endtask

    task automatic test_polarity_disable();
        int hi = 0, cs = 0;
        bit found = 1'b0;
        @(negedge clk); configure(0, 9, 1'b0, '0); write_duty(0, 3); enable();
        repeat (10) @(negedge clk);
        polarity = CH'(1);
        @(negedge clk);
        repeat (20) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL polarity_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            hi += int'(pwm[0]);
        end
        checks++;
        if (hi != 14) begin
            errors++; $display("FAIL polarity_invert: highs=%0d required 14", hi);
        end
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk); found = (m_k == 5);
        end
        en = 1'b0; hi = 0;
        repeat (10) begin
            @(negedge clk); hi += int'(pwm[0]); cs += int'(cycle_start);
        end
        checks++;
        if (!found || hi != 10 || cs != 0) begin
            errors++; $display("FAIL disable_idle: found=%0d highs=%0d starts=%0d required 1 10 0", found, hi, cs);
        end
        en = 1'b1; cs = 0;
        @(negedge clk); checks++;
        if (pwm[0] !== 1'b0) begin
            errors++; $display("FAIL reenable_first: pwm0=%b required 0", pwm[0]);
        end
        repeat (9) begin
            @(negedge clk); cs += int'(cycle_start);
        end
        checks++;
        if (cs != 1 || cycle_start !== 1'b1) begin
            errors++; $display("FAIL reenable_wrap: starts=%0d last=%b required 1 and 1", cs, cycle_start);
        end
        polarity = '0;
    endtask

    task automatic test_limits();
        int cs = 0;
        bit found = 1'b0;
        for (int m = 0; m < 2; m++) begin
            @(negedge clk); configure(0, 0, m[0], '0); enable(); cs = 0;
            repeat (10) begin
                @(negedge clk); cs += int'(cycle_start);
            end
            checks++;
            if (cs != 10) begin
                errors++; $display("FAIL zero_period mode=%0d: starts=%0d required 10", m, cs);
            end
        end
        @(negedge clk); configure(0, 9, 1'b0, '0); enable();
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk); found = (m_k == 6);
        end
        period = DW'(2);
        @(negedge clk); checks++;
        if (!found || cycle_start !== 1'b1) begin
            errors++; $display("FAIL period_shrink: found=%0d cs=%b required 1 and 1", found, cycle_start);
        end
        cs = 0;
        repeat (12) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL shrink_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            cs += int'(cycle_start);
        end
        checks++;
        if (cs != 4) begin
            errors++; $display("FAIL shrink_rate: starts=%0d required 4", cs);
        end
    endtask

    task automatic test_reset_pulse();
        int nz = 0, cs = 0;
        bit found = 1'b0;
        @(negedge clk); configure(0, 9, 1'b0, '0);
        for (int c = 0; c < CH; c++) write_duty(c, 12);
        enable();
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk); found = (m_k == 4);
        end
        checks++;
        if (!found || pwm !== {CH{1'b1}}) begin
            errors++; $display("FAIL pre_reset: found=%0d pwm=%b required 1 and all ones", found, pwm);
        end
        #2 rst_n = 1'b0;
        #1 checks++;
        if (pwm !== '0 || cycle_start !== 1'b0) begin
            errors++; $display("FAIL async_reset: pwm=%b cs=%b required 0 0", pwm, cycle_start);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL post_reset_model: pwm=%b cs=%b required pwm=%b cs=%b", pwm, cycle_start, exp_pwm, exp_cs);
            end
            nz += int'(pwm != '0); cs += int'(cycle_start);
        end
        checks++;
        if (nz != 0 || cs != 3) begin
            errors++; $display("FAIL post_reset_duty: nonzero=%0d starts=%0d required 0 and 3", nz, cs);
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk); checks++;
            if (pwm !== exp_pwm || cycle_start !== exp_cs) begin
                errors++; $display("FAIL random_model @%0d: pwm=%b cs=%b required pwm=%b cs=%b", n, pwm, cycle_start, exp_pwm, exp_cs);
            end
            duty_wr = 1'b0;
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                en = 1'b0; div = DVW'($urandom_range(0, 3));
                period = DW'($urandom_range(0, 15)); mode = 1'($urandom_range(0, 1));
            end else if (r == 1) begin
                polarity = CH'($urandom);
            end else if (r == 2) begin
                en = 1'b0;
            end else if (!en && r < 10) begin
                en = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) begin
                duty_wr = 1'b1; duty_sel = SW'($urandom_range(0, 7));
                duty_data = DW'($urandom_range(0, 17));
            end
        end
        duty_wr = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_edge_basic();
        test_prescale();
        test_shadow();
        test_center();
        test_polarity_disable();
        test_limits();
        test_reset_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
